// File: rtl/chip8_keypad_scanner.sv
// 4x4 hex keypad scanner feeding the chip8 core.
// Column strobe, row sync, per-key debounce and a newest-press latch.
module chip8_keypad_scanner #(
    parameter int COL_CYCLES     = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  keypad_rows,
    output logic [3:0]  keypad_cols,
    input  logic        clear_newest_key_down,
    output logic [15:0] input_keys,
    output logic [4:0]  newest_key_down
);

    localparam int DW = $clog2(COL_CYCLES);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(COL_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [4:0]    NO_KEY     = 5'd16;

    logic [3:0]    row_m;
    logic [3:0]    row_q;
    logic [3:0]    row_s;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [1:0]    col_nxt;
    logic          sample;

    logic [CW-1:0] deb_cnt [16];
    logic [CW-1:0] cnt_nxt [16];
    logic [15:0]   keys_nxt;
    logic [15:0]   rise;
    logic [4:0]    newest_nxt;

    function automatic logic [3:0] key_at(
        input logic [1:0] r,
        input logic [1:0] c
    );
        logic [3:0] v;
        case ({r, c})
            4'b00_00: v = 4'h1;
            4'b00_01: v = 4'h2;
            4'b00_10: v = 4'h3;
            4'b00_11: v = 4'hC;
            4'b01_00: v = 4'h4;
            4'b01_01: v = 4'h5;
            4'b01_10: v = 4'h6;
            4'b01_11: v = 4'hD;
            4'b10_00: v = 4'h7;
            4'b10_01: v = 4'h8;
            4'b10_10: v = 4'h9;
            4'b10_11: v = 4'hE;
            4'b11_00: v = 4'hA;
            4'b11_01: v = 4'h0;
            4'b11_10: v = 4'hB;
            default:  v = 4'hF;
        endcase
        return v;
    endfunction

    assign row_s   = ~row_q;
    assign sample  = (dwell == DWELL_LAST);
    assign col_nxt = col_idx + 2'd1;

    // Rows are asynchronous to clk; two flops before any decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_m <= 4'b1111;
            row_q <= 4'b1111;
        end else begin
            row_m <= keypad_rows;
            row_q <= row_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell       <= '0;
            col_idx     <= 2'd0;
            keypad_cols <= 4'b1110;
        end else if (sample) begin
            dwell       <= '0;
            col_idx     <= col_nxt;
            keypad_cols <= ~(4'b0001 << col_nxt);
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_comb begin
        logic [3:0] k;
        k        = 4'h0;
        keys_nxt = input_keys;
        rise     = '0;
        for (int i = 0; i < 16; i++) cnt_nxt[i] = deb_cnt[i];
        if (sample) begin
            for (int r = 0; r < 4; r++) begin
                k = key_at(2'(r), col_idx);
                if (row_s[r] == input_keys[k]) begin
                    cnt_nxt[k] = '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    keys_nxt[k] = row_s[r];
                    rise[k]     = row_s[r];
                    cnt_nxt[k]  = '0;
                end else begin
                    cnt_nxt[k] = deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    // A fresh press outranks a clear; the lowest hex value wins ties.
    always_comb begin
        newest_nxt = newest_key_down;
        if (clear_newest_key_down) newest_nxt = NO_KEY;
        for (int i = 15; i >= 0; i--) begin
            if (rise[i]) newest_nxt = 5'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            input_keys      <= '0;
            newest_key_down <= NO_KEY;
            for (int i = 0; i < 16; i++) deb_cnt[i] <= '0;
        end else begin
            input_keys      <= keys_nxt;
            newest_key_down <= newest_nxt;
            for (int i = 0; i < 16; i++) deb_cnt[i] <= cnt_nxt[i];
        end
    end

endmodule

// File: tb/tb_chip8_keypad_scanner.sv
// Directed bench for chip8_keypad_scanner.
// Scan is 8 clks per column, 3 samples to debounce.
module tb_chip8_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  keypad_rows;
    logic [3:0]  keypad_cols;
    logic        clear_newest_key_down = 1'b0;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;

    logic [15:0] held = '0;
    int          n;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    chip8_keypad_scanner #(
        .COL_CYCLES(8),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .keypad_rows(keypad_rows),
        .keypad_cols(keypad_cols),
        .clear_newest_key_down(clear_newest_key_down),
        .input_keys(input_keys),
        .newest_key_down(newest_key_down)
    );

    // held bit r*4+c shorts row r to column c
    always_comb begin
        keypad_rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !keypad_cols[c]) keypad_rows[r] = 1'b0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n <= 0;
        else n <= n + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        held = '0;
        clear_newest_key_down = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Park on the negedge right after column c is sampled.
    task automatic goto_sample(input int c);
        bit hit;
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (n > 0 && n % 8 == 0 && ((n - 1) / 8) % 4 == c) hit = 1;
        end
        if (!hit) begin
            failures++;
            $display("FAIL goto_sample col=%0d not reached", c);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (keypad_cols !== 4'b1110) begin
            failures++;
            $display("FAIL reset_cols got=%b exp=1110", keypad_cols);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 40; j++) begin
            exp_cols = ~(4'b0001 << ((j / 8) % 4));
            checks++;
            if (keypad_cols !== exp_cols) begin
                failures++;
                $display("FAIL scan_cols j=%0d got=%b exp=%b", j, keypad_cols, exp_cols);
            end
            checks++;
            if (input_keys !== 16'h0 || newest_key_down !== 5'd16) begin
                failures++;
                $display("FAIL idle_keys j=%0d got=%h/%0d exp=0000/16",
                         j, input_keys, newest_key_down);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_press_release();
        do_reset();
        goto_sample(2);
        held[1*4+2] = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            goto_sample(2);
            checks++;
            if (s < 3 && input_keys !== 16'h0) begin
                failures++;
                $display("FAIL press_early s=%0d got=%h exp=0000", s, input_keys);
            end else if (s == 3 && (input_keys !== 16'h0040 || newest_key_down !== 5'd6)) begin
                failures++;
                $display("FAIL press_key6 got=%h/%0d exp=0040/6", input_keys, newest_key_down);
            end
        end
        held = '0;
        for (int s = 1; s <= 3; s++) begin
            goto_sample(2);
            checks++;
            if (s < 3 && input_keys !== 16'h0040) begin
                failures++;
                $display("FAIL release_early s=%0d got=%h exp=0040", s, input_keys);
            end else if (s == 3 && (input_keys !== 16'h0 || newest_key_down !== 5'd6)) begin
                failures++;
                $display("FAIL release_key6 got=%h/%0d exp=0000/6", input_keys, newest_key_down);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        goto_sample(1);
        held[3*4+1] = 1'b1;
        repeat (2) goto_sample(1);
        held = '0;
        for (int s = 0; s < 4; s++) begin
            goto_sample(1);
            checks++;
            if (input_keys !== 16'h0 || newest_key_down !== 5'd16) begin
                failures++;
                $display("FAIL bounce s=%0d got=%h/%0d exp=0000/16",
                         s, input_keys, newest_key_down);
            end
        end
    endtask

    task automatic test_two_keys();
        do_reset();
        goto_sample(3);
        held[0*4+3] = 1'b1;
        held[3*4+3] = 1'b1;
        repeat (2) goto_sample(3);
        checks++;
        if (input_keys !== 16'h0) begin
            failures++;
            $display("FAIL two_early got=%h exp=0000", input_keys);
        end
        goto_sample(3);
        checks++;
        if (input_keys !== 16'h9000 || newest_key_down !== 5'd12) begin
            failures++;
            $display("FAIL two_keys got=%h/%0d exp=9000/12", input_keys, newest_key_down);
        end
    endtask

    task automatic test_clear();
        bit hit;
        do_reset();
        goto_sample(2);
        held[1*4+2] = 1'b1;
        repeat (3) goto_sample(2);
        checks++;
        if (newest_key_down !== 5'd6) begin
            failures++;
            $display("FAIL clear_pre got=%0d exp=6", newest_key_down);
        end
        clear_newest_key_down = 1'b1;
        @(negedge clk);
        clear_newest_key_down = 1'b0;
        checks++;
        if (newest_key_down !== 5'd16 || input_keys !== 16'h0040) begin
            failures++;
            $display("FAIL clear_alone got=%h/%0d exp=0040/16", input_keys, newest_key_down);
        end
        goto_sample(0);
        held[2*4+0] = 1'b1;
        repeat (2) goto_sample(0);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (n % 32 == 7) hit = 1;
        end
        clear_newest_key_down = 1'b1;
        @(negedge clk);
        clear_newest_key_down = 1'b0;
        checks++;
        if (!hit || newest_key_down !== 5'd7 || input_keys !== 16'h00C0) begin
            failures++;
            $display("FAIL clear_vs_press hit=%0d got=%h/%0d exp=00c0/7",
                     hit, input_keys, newest_key_down);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        goto_sample(1);
        held[1*4+1] = 1'b1;
        repeat (3) goto_sample(1);
        checks++;
        if (input_keys !== 16'h0020 || newest_key_down !== 5'd5) begin
            failures++;
            $display("FAIL key5_pre got=%h/%0d exp=0020/5", input_keys, newest_key_down);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (input_keys !== 16'h0 || newest_key_down !== 5'd16 || keypad_cols !== 4'b1110) begin
            failures++;
            $display("FAIL mid_reset got=%h/%0d/%b exp=0000/16/1110",
                     input_keys, newest_key_down, keypad_cols);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) goto_sample(1);
        checks++;
        if (input_keys !== 16'h0) begin
            failures++;
            $display("FAIL rescan_early got=%h exp=0000", input_keys);
        end
        goto_sample(1);
        checks++;
        if (input_keys !== 16'h0020 || newest_key_down !== 5'd5) begin
            failures++;
            $display("FAIL rescan_key5 got=%h/%0d exp=0020/5", input_keys, newest_key_down);
        end
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_two_keys();
        test_clear();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
